// File: rtl/rot_decipher_stream_if.sv
// Stream bundle for the rotate-cipher decryptor: ciphertext in, plaintext out.
//   in_valid/in_ready/din    : ciphertext beat handshake
//   out_valid/out_ready/dout : plaintext handshake at the output FIFO head
// slave is the decryptor's view; master is the source/consumer side.
interface rot_decipher_stream_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] dout;

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout
    );

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout
    );
endinterface

// File: rtl/rot_decipher_stream.sv
// Rotate-cipher decryptor: latched key, two-stage datapath, DEPTH-entry output FIFO.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   key_load_i   : request to latch key_dir_i / key_shift_i
//   key_dir_i    : 00 none, 01 rotl, 10 rotr, 11 rotl-then-invert (encrypt side)
//   key_shift_i  : rotate amount, taken mod N
//   key_err_o    : one-cycle pulse after a rejected key_load_i
//   blk_cnt_o    : wrapping count of output handshakes
//   s            : stream interface (slave modport)
module rot_decipher_stream #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_load_i,
    input  logic [1:0]  key_dir_i,
    input  logic [4:0]  key_shift_i,
    output logic        key_err_o,
    output logic [15:0] blk_cnt_o,
    rot_decipher_stream_if.slave s
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] DIR_ROTL = 2'b01;
    localparam logic [1:0] DIR_ROTR = 2'b10;
    localparam logic [1:0] DIR_INV  = 2'b11;

    logic [1:0]    key_dir_q, key_dir_d;
    logic [SW-1:0] key_sh_q, key_sh_d;
    logic          key_err_q, key_err_d;
    logic          s1_v_q, s1_v_d;
    logic [N-1:0]  s1_d_q, s1_d_d;
    logic          s2_v_q, s2_v_d;
    logic [N-1:0]  s2_d_q, s2_d_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;
    logic [N-1:0]  mem_q [DEPTH];

    logic [CW:0]   credit;
    logic          in_ready_c;
    logic          accept;
    logic          key_ok;
    logic          push;
    logic          pop;
    logic          out_valid_c;

    function automatic logic [N-1:0] rot_r(input logic [N-1:0] x, input logic [SW-1:0] a);
        logic [2*N-1:0] t;
        t = {x, x} >> a;
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] rot_l(input logic [N-1:0] x, input logic [SW-1:0] a);
        logic [2*N-1:0] t;
        t = {x, x} << a;
        return t[2*N-1:N];
    endfunction

    // Credit check counts in-flight beats so the pipeline never has to stall.
    assign credit      = (CW+1)'(cnt_q) + (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
    assign in_ready_c  = !key_load_i && (credit < (CW+1)'(DEPTH));
    assign accept      = s.in_valid && in_ready_c;
    assign key_ok      = key_load_i && !s1_v_q && !s2_v_q && !accept;
    assign out_valid_c = (cnt_q != '0);
    assign push        = s2_v_q;
    assign pop         = out_valid_c && s.out_ready;

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = out_valid_c;
    assign s.dout      = out_valid_c ? mem_q[rd_ptr_q] : '0;
    assign key_err_o   = key_err_q;
    assign blk_cnt_o   = blk_cnt_q;

    // Next-state for key, pipeline stages, FIFO bookkeeping and counter.
    always_comb begin
        key_dir_d = key_dir_q;
        key_sh_d  = key_sh_q;
        key_err_d = key_load_i && !key_ok;
        if (key_ok) begin
            key_dir_d = key_dir_i;
            key_sh_d  = SW'({1'b0, key_shift_i} % 6'(N));
        end

        s1_v_d = accept;
        s1_d_d = (key_dir_q == DIR_INV) ? ~s.din : s.din;

        // Stage 2 undoes the encrypt-side rotation (key cannot change while s1 is busy).
        s2_v_d = s1_v_q;
        s2_d_d = s1_d_q;
        case (key_dir_q)
            DIR_ROTL, DIR_INV: s2_d_d = rot_r(s1_d_q, key_sh_q);
            DIR_ROTR:          s2_d_d = rot_l(s1_d_q, key_sh_q);
            default:           s2_d_d = s1_d_q;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        blk_cnt_d = pop ? blk_cnt_q + 16'd1 : blk_cnt_q;
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_dir_q <= '0;
            key_sh_q  <= '0;
            key_err_q <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_d_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_d_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            blk_cnt_q <= '0;
        end else begin
            key_dir_q <= key_dir_d;
            key_sh_q  <= key_sh_d;
            key_err_q <= key_err_d;
            s1_v_q    <= s1_v_d;
            s1_d_q    <= s1_d_d;
            s2_v_q    <= s2_v_d;
            s2_d_q    <= s2_d_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // FIFO storage; contents are qualified by cnt_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s2_d_q;
        end
    end

endmodule

// File: tb/tb_rot_decipher_stream.sv
// Directed bench for rot_decipher_stream (N=8, DEPTH=4).
module tb_rot_decipher_stream;

    logic        clk;
    logic        rst_n;
    logic        key_load;
    logic [1:0]  key_dir;
    logic [4:0]  key_shift;
    logic        key_err;
    logic [15:0] blk_cnt;

    int errors = 0;
    int checks = 0;
    int acc;

    logic [7:0] fv [6];
    logic [7:0] fe [4];

    rot_decipher_stream_if #(.N(8)) bus ();

    rot_decipher_stream #(.N(8), .DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_load_i  (key_load),
        .key_dir_i   (key_dir),
        .key_shift_i (key_shift),
        .key_err_o   (key_err),
        .blk_cnt_o   (blk_cnt),
        .s           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fv = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
        fe = '{8'h80, 8'h01, 8'h02, 8'h04};
        rst_n = 1'b0; key_load = 1'b0; key_dir = 2'b00; key_shift = 5'd0;
        bus.in_valid = 1'b0; bus.din = 8'h00; bus.out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_key_err", 32'(key_err), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic decrypt, key 01/3
        key_load = 1'b1; key_dir = 2'b01; key_shift = 5'd3;
        settle();
        chk("kl_blocks_ready", 32'(bus.in_ready), 32'd0);
        step();
        key_load = 1'b0;
        settle();
        chk("basic_key_err", 32'(key_err), 32'd0);
        bus.in_valid = 1'b1; bus.din = 8'h1E;
        settle();
        chk("basic_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        settle();
        chk("lat_k", 32'(bus.out_valid), 32'd0);
        step();
        chk("lat_k1", 32'(bus.out_valid), 32'd0);
        step();
        chk("lat_k2_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_dout", 32'(bus.dout), 32'hC3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        settle();
        chk("basic_blk_cnt", 32'(blk_cnt), 32'd1);
        chk("basic_empty", 32'(bus.out_valid), 32'd0);
        chk("empty_dout", 32'(bus.dout), 32'h0);

        // Rotate-right key with shift 11 (mod 8 = 3), back-to-back beats
        key_load = 1'b1; key_dir = 2'b10; key_shift = 5'd11;
        step();
        key_load = 1'b0;
        bus.in_valid = 1'b1; bus.din = 8'h78;
        step();
        step();
        bus.in_valid = 1'b0;
        step();
        chk("rotr_b0_valid", 32'(bus.out_valid), 32'd1);
        chk("rotr_b0_dout", 32'(bus.dout), 32'hC3);
        bus.out_ready = 1'b1;
        step();
        chk("rotr_b1_valid", 32'(bus.out_valid), 32'd1);
        chk("rotr_b1_dout", 32'(bus.dout), 32'hC3);
        step();
        bus.out_ready = 1'b0;
        settle();
        chk("rotr_empty", 32'(bus.out_valid), 32'd0);
        chk("rotr_blk_cnt", 32'(blk_cnt), 32'd3);

        // Invert key 11/1
        key_load = 1'b1; key_dir = 2'b11; key_shift = 5'd1;
        step();
        key_load = 1'b0;
        bus.in_valid = 1'b1; bus.din = 8'hFC;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("inv_valid", 32'(bus.out_valid), 32'd1);
        chk("inv_dout", 32'(bus.dout), 32'h81);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Full FIFO with backpressure, key still 11/1
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.din = fv[i];
            settle();
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        settle();
        chk("full_accepted", 32'(acc), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_dout", 32'(bus.dout), 32'h80);
        step(); step();
        chk("full_hold_dout", 32'(bus.dout), 32'h80);
        chk("full_hold_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_dout", 32'(bus.dout), 32'(fe[j]));
            if (j == 0) chk("pre_pop_ready", 32'(bus.in_ready), 32'd0);
            step();
            if (j == 0) chk("release_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.out_ready = 1'b0;
        settle();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
        chk("drain_blk_cnt", 32'(blk_cnt), 32'd8);

        // Key rejection while a beat sits in stage 1
        bus.in_valid = 1'b1; bus.din = 8'hFE;
        step();
        bus.in_valid = 1'b0;
        key_load = 1'b1; key_dir = 2'b00; key_shift = 5'd0;
        settle();
        chk("rej_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        key_load = 1'b0;
        settle();
        chk("rej_key_err", 32'(key_err), 32'd1);
        step();
        chk("rej_key_err_pulse", 32'(key_err), 32'd0);
        chk("rej_inflight_dout", 32'(bus.dout), 32'h80);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.din = 8'hFD;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("old_key_dout", 32'(bus.dout), 32'h01);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Key load with empty pipeline is accepted
        key_load = 1'b1; key_dir = 2'b01; key_shift = 5'd3;
        step();
        key_load = 1'b0;
        settle();
        chk("ok_key_err", 32'(key_err), 32'd0);
        bus.in_valid = 1'b1; bus.din = 8'h1E;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("new_key_dout", 32'(bus.dout), 32'hC3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        settle();
        chk("rej_blk_cnt", 32'(blk_cnt), 32'd11);

        // Reset mid-stream: 2 in FIFO, 1 in flight
        bus.in_valid = 1'b1; bus.din = 8'h1E;
        step();
        bus.din = 8'h3C;
        step();
        bus.din = 8'h78;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("pre_rst_dout", 32'(bus.dout), 32'hC3);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_dout", 32'(bus.dout), 32'h0);
        chk("mid_rst_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_discard", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1; bus.din = 8'h5A;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("pass_valid", 32'(bus.out_valid), 32'd1);
        chk("pass_dout", 32'(bus.dout), 32'h5A);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        settle();
        chk("pass_blk_cnt", 32'(blk_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
